// File: rtl/ddr_pkg.sv
// Shared types and widths for the DDR controller front end.
package ddr_pkg;

    localparam int DDR_ADDR_W = 27;
    localparam int DDR_DATA_W = 32;

    typedef logic [0:0] clientId_t;

    typedef enum logic {
        IDLE,
        ISSUE
    } arbState_e;

endpackage

// File: rtl/ddr_read_tracker.sv
// Fixed-latency shift register carrying the issuing client id of each read
// so returning data can be routed back in issue order.
module ddr_read_tracker
    import ddr_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  clientId_t id_i,
    output logic      valid_o,
    output clientId_t id_o
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] id_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            id_q    <= '0;
        end else begin
            valid_q[0] <= push_i;
            id_q[0]    <= id_i[0];
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                id_q[i]    <= id_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign id_o    = clientId_t'(id_q[DEPTH-1]);

endmodule

// File: rtl/ddr_client_arbiter.sv
// Two-client arbiter in front of the DDR command stage, with read-data routing
// and refresh strobe. Define DDR_RR_ARB_EN for round-robin instead of C0 priority.
module ddr_client_arbiter
    import ddr_pkg::*;
#(
    parameter int READ_LATENCY     = 3,
    parameter int REFRESH_INTERVAL = 1560,
    parameter int REFRESH_W        = 11
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  C0_REQ,
    input  logic                  C1_REQ,
    input  logic                  C0_WE,
    input  logic                  C1_WE,
    input  logic [DDR_ADDR_W-1:0] C0_ADDR,
    input  logic [DDR_ADDR_W-1:0] C1_ADDR,
    input  logic [DDR_DATA_W-1:0] C0_WDATA,
    input  logic [DDR_DATA_W-1:0] C1_WDATA,
    output logic                  C0_ACK,
    output logic                  C1_ACK,
    output logic                  C0_RVALID,
    output logic                  C1_RVALID,
    output logic [DDR_DATA_W-1:0] RDATA,
    output logic [DDR_ADDR_W-1:0] ADDRESS_REQ,
    output logic                  WE,
    output logic [DDR_DATA_W-1:0] DATA_W,
    output logic                  DO_ACT,
    input  logic                  COMMAND_LATCHED,
    input  logic [DDR_DATA_W-1:0] DATA_R,
    output logic                  REFRESH_STROBE
);

    arbState_e             state_q, state_d;
    clientId_t             grantId_q, grantId_d;
    logic [DDR_ADDR_W-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DDR_DATA_W-1:0] dataW_q, dataW_d;
    logic                  doAct_q, doAct_d;
    logic                  ack0_q, ack0_d, ack1_q, ack1_d;
    logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DDR_DATA_W-1:0] rdata_q, rdata_d;
    logic [REFRESH_W-1:0]  refCnt_q, refCnt_d;
    logic                  strobe_q, strobe_d;

    logic      reqMasked0, reqMasked1;
    clientId_t grantSel;
    logic      trkPush, trkValid;
    clientId_t trkId;

    // A client seeing its ACK this cycle still has the old REQ up; ignore it.
    assign reqMasked0 = C0_REQ & ~ack0_q;
    assign reqMasked1 = C1_REQ & ~ack1_q;

`ifdef DDR_RR_ARB_EN
    assign grantSel = (reqMasked0 && reqMasked1) ? ~grantId_q : clientId_t'(reqMasked1);
`else
    assign grantSel = clientId_t'(~reqMasked0);
`endif

    assign trkPush = (state_q == ISSUE) && COMMAND_LATCHED && !we_q;

    ddr_read_tracker #(
        .DEPTH(READ_LATENCY)
    ) u_tracker (
        .clk_i  (CLK),
        .rst_i  (RST),
        .push_i (trkPush),
        .id_i   (grantId_q),
        .valid_o(trkValid),
        .id_o   (trkId)
    );

    always_comb begin
        state_d   = state_q;
        grantId_d = grantId_q;
        addr_d    = addr_q;
        we_d      = we_q;
        dataW_d   = dataW_q;
        doAct_d   = doAct_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (reqMasked0 || reqMasked1) begin
                    grantId_d = grantSel;
                    addr_d    = grantSel[0] ? C1_ADDR  : C0_ADDR;
                    we_d      = grantSel[0] ? C1_WE    : C0_WE;
                    dataW_d   = grantSel[0] ? C1_WDATA : C0_WDATA;
                    doAct_d   = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (COMMAND_LATCHED) begin
                    ack0_d  = ~grantId_q[0];
                    ack1_d  = grantId_q[0];
                    doAct_d = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        rvalid0_d = trkValid && !trkId[0];
        rvalid1_d = trkValid && trkId[0];
        rdata_d   = trkValid ? DATA_R : rdata_q;
        refCnt_d  = refCnt_q + REFRESH_W'(1);
        strobe_d  = strobe_q;
        if (refCnt_q == REFRESH_W'(REFRESH_INTERVAL - 1)) begin
            refCnt_d = '0;
            strobe_d = ~strobe_q;
        end
    end

    // grantId resets to C1 so that a round-robin build favours C0 first.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            grantId_q <= clientId_t'(1'b1);
            addr_q    <= '0;
            we_q      <= 1'b0;
            dataW_q   <= '0;
            doAct_q   <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata_q   <= '0;
            refCnt_q  <= '0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grantId_q <= grantId_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            dataW_q   <= dataW_d;
            doAct_q   <= doAct_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata_q   <= rdata_d;
            refCnt_q  <= refCnt_d;
            strobe_q  <= strobe_d;
        end
    end

    assign ADDRESS_REQ    = addr_q;
    assign WE             = we_q;
    assign DATA_W         = dataW_q;
    assign DO_ACT         = doAct_q;
    assign C0_ACK         = ack0_q;
    assign C1_ACK         = ack1_q;
    assign C0_RVALID      = rvalid0_q;
    assign C1_RVALID      = rvalid1_q;
    assign RDATA          = rdata_q;
    assign REFRESH_STROBE = strobe_q;

endmodule
